// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding selects, load-use / branch / stack-op stalls for the
// five-stage MIPS core with stack extensions.
module hazard_ctrl #(
    parameter int unsigned STK_CYCLES = 2
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [4:0] RsD,
    input  logic [4:0] RtD,
    input  logic [4:0] RsE,
    input  logic [4:0] RtE,
    input  logic [4:0] WriteRegE,
    input  logic [4:0] WriteRegM,
    input  logic [4:0] WriteRegW,
    input  logic       RegWriteE,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       MemtoRegM,
    input  logic       BranchD,
    input  logic       PushE,
    input  logic       PopE,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       ForwardAD,
    output logic       ForwardBD,
    output logic       StkBusy
);

    // A two-cycle stack op needs only the stkstart bubble; longer ones park in STK.
    localparam bit         UseStk  = (STK_CYCLES > 32'd2);
    localparam logic [3:0] CntLoad = UseStk ? 4'(STK_CYCLES - 32'd3) : 4'd0;

    typedef enum logic {StRun, StStk} state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic m_fwd_rse, w_fwd_rse, m_fwd_rte, w_fwd_rte;
    logic m_fwd_rsd, m_fwd_rtd;
    logic lwstall, brstall, stkstart, hold;

    // Per-source match terms; register 0 is never a forwarding source.
    always_comb begin
        m_fwd_rse = RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsE);
        w_fwd_rse = RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RsE);
        m_fwd_rte = RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtE);
        w_fwd_rte = RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RtE);
        m_fwd_rsd = RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsD);
        m_fwd_rtd = RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtD);
    end

    // Hazard terms feeding the single hold signal.
    always_comb begin
        lwstall  = MemtoRegE && ((RtE == RsD) || (RtE == RtD));
        brstall  = BranchD &&
                   ((RegWriteE && (WriteRegE != 5'd0) &&
                     ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                    (MemtoRegM && (WriteRegM != 5'd0) &&
                     ((WriteRegM == RsD) || (WriteRegM == RtD))));
        stkstart = (state_q == StRun) && (PushE || PopE);
        hold     = lwstall || brstall || stkstart || (state_q == StStk);
    end

    // Stack sequencer next state: cnt counts the bubbles still owed after this one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StRun: begin
                if (stkstart && UseStk) begin
                    state_d = StStk;
                    cnt_d   = CntLoad;
                end
            end
            StStk: begin
                if (cnt_q == 4'd0) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = StRun;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Sequencer state register; reset aborts any stack sequence in flight.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are forced low while reset is high, whatever the inputs do.
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushE    = 1'b0;
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        ForwardAD = 1'b0;
        ForwardBD = 1'b0;
        StkBusy   = 1'b0;
        if (!reset) begin
            StallF    = hold;
            StallD    = hold;
            FlushE    = hold;
            ForwardAE = m_fwd_rse ? 2'b10 : (w_fwd_rse ? 2'b01 : 2'b00);
            ForwardBE = m_fwd_rte ? 2'b10 : (w_fwd_rte ? 2'b01 : 2'b00);
            ForwardAD = m_fwd_rsd;
            ForwardBD = m_fwd_rtd;
            StkBusy   = (state_q == StStk);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three instances (STK_CYCLES 2, 4, 6) share one input set;
// expectations are queued when stimulus is driven and compared at the next negedge.
module tb_hazard_ctrl;

    logic       CLK;
    logic       reset;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM;
    logic       BranchD, PushE, PopE;

    // Index 0: STK_CYCLES=2, 1: STK_CYCLES=4, 2: STK_CYCLES=6.
    logic [2:0] stall_f, stall_d, flush_e, stk_busy;
    logic [1:0] fae [3];
    logic [1:0] fbe [3];
    logic       fad [3];
    logic       fbd [3];

    typedef struct packed {
        logic [2:0] stall_f;
        logic [2:0] stall_d;
        logic [2:0] flush_e;
        logic [2:0] busy;
        logic [1:0] fae;
        logic [1:0] fbe;
        logic       fad;
        logic       fbd;
    } obs_t;

    obs_t exp_q [$];
    int   checks   = 0;
    int   failures = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hazard_ctrl #(.STK_CYCLES(2 + 2 * g)) u_dut (
            .CLK       (CLK),
            .reset     (reset),
            .RsD       (RsD),
            .RtD       (RtD),
            .RsE       (RsE),
            .RtE       (RtE),
            .WriteRegE (WriteRegE),
            .WriteRegM (WriteRegM),
            .WriteRegW (WriteRegW),
            .RegWriteE (RegWriteE),
            .RegWriteM (RegWriteM),
            .RegWriteW (RegWriteW),
            .MemtoRegE (MemtoRegE),
            .MemtoRegM (MemtoRegM),
            .BranchD   (BranchD),
            .PushE     (PushE),
            .PopE      (PopE),
            .StallF    (stall_f[g]),
            .StallD    (stall_d[g]),
            .FlushE    (flush_e[g]),
            .ForwardAE (fae[g]),
            .ForwardBE (fbe[g]),
            .ForwardAD (fad[g]),
            .ForwardBD (fbd[g]),
            .StkBusy   (stk_busy[g])
        );
    end

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Forwarding is compared on the STK_CYCLES=4 instance, plus cross-instance agreement.
    function automatic obs_t observe();
        obs_t o;
        o.stall_f = stall_f;
        o.stall_d = stall_d;
        o.flush_e = flush_e;
        o.busy    = stk_busy;
        o.fae     = (fae[0] == fae[1] && fae[2] == fae[1]) ? fae[1] : 2'bxx;
        o.fbe     = (fbe[0] == fbe[1] && fbe[2] == fbe[1]) ? fbe[1] : 2'bxx;
        o.fad     = (fad[0] == fad[1] && fad[2] == fad[1]) ? fad[1] : 1'bx;
        o.fbd     = (fbd[0] == fbd[1] && fbd[2] == fbd[1]) ? fbd[1] : 1'bx;
        return o;
    endfunction

    function automatic obs_t mk(logic [2:0] hold, logic [2:0] busy, logic [1:0] ae,
                                logic [1:0] be, logic ad, logic bd);
        obs_t o;
        o.stall_f = hold;
        o.stall_d = hold;
        o.flush_e = hold;
        o.busy    = busy;
        o.fae     = ae;
        o.fbe     = be;
        o.fad     = ad;
        o.fbd     = bd;
        return o;
    endfunction

    task automatic idle();
        RsD = 0; RtD = 0; RsE = 0; RtE = 0;
        WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
        MemtoRegE = 0; MemtoRegM = 0; BranchD = 0; PushE = 0; PopE = 0;
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        obs_t got, want;
        for (int c = 0; c < 2; c++) begin
            idle();
            case (c)
                0: begin
                    reset = 1'b1;
                    RegWriteM = 1; WriteRegM = 8; RsE = 8;
                    MemtoRegE = 1; RtE = 9; RtD = 9; PushE = 1;
                end
                default: reset = 1'b0;
            endcase
            exp_q.push_back(mk(3'b000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
            @(negedge CLK);
            got = observe(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset c%0d got=%h want=%h", c, got, want);
            end
            next_cycle();
        end
    endtask

    task automatic test_forward();
        obs_t got, want;
        for (int c = 0; c < 5; c++) begin
            idle();
            case (c)
                0: begin
                    RegWriteM = 1; WriteRegM = 8; RsE = 8; RegWriteW = 1; WriteRegW = 8;
                    exp_q.push_back(mk(3'b000, 3'b000, 2'b10, 2'b00, 1'b0, 1'b0));
                end
                1: begin
                    RegWriteM = 1; WriteRegM = 0; RsE = 0; RegWriteW = 1; WriteRegW = 8;
                    exp_q.push_back(mk(3'b000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
                end
                2: begin
                    RegWriteM = 1; WriteRegM = 3; RegWriteW = 1; WriteRegW = 4;
                    RsE = 4; RtE = 3; RsD = 3; RtD = 3;
                    exp_q.push_back(mk(3'b000, 3'b000, 2'b01, 2'b10, 1'b1, 1'b1));
                end
                3: begin
                    RegWriteM = 0; WriteRegM = 3; RegWriteW = 1; WriteRegW = 4;
                    RsE = 4; RtE = 3; RsD = 3; RtD = 3;
                    exp_q.push_back(mk(3'b000, 3'b000, 2'b01, 2'b00, 1'b0, 1'b0));
                end
                default: begin
                    RegWriteM = 1; WriteRegM = 0; RegWriteW = 1; WriteRegW = 0;
                    exp_q.push_back(mk(3'b000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
                end
            endcase
            @(negedge CLK);
            got = observe(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL forward c%0d got=%h want=%h", c, got, want);
            end
            next_cycle();
        end
    endtask

    task automatic test_load_use();
        obs_t got, want;
        for (int c = 0; c < 4; c++) begin
            idle();
            case (c)
                0: begin
                    MemtoRegE = 1; RtE = 9; RtD = 9; RsD = 1;
                    exp_q.push_back(mk(3'b111, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
                end
                1: begin
                    RtD = 9; RsD = 1;
                    exp_q.push_back(mk(3'b000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
                end
                2: begin
                    MemtoRegE = 1; RtE = 7; RsD = 7; RtD = 2;
                    exp_q.push_back(mk(3'b111, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
                end
                default: begin
                    MemtoRegE = 1; RtE = 7; RsD = 6; RtD = 2;
                    exp_q.push_back(mk(3'b000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
                end
            endcase
            @(negedge CLK);
            got = observe(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL load_use c%0d got=%h want=%h", c, got, want);
            end
            next_cycle();
        end
    endtask

    task automatic test_branch();
        obs_t got, want;
        for (int c = 0; c < 5; c++) begin
            idle();
            BranchD = 1; RsD = 5;
            case (c)
                0: begin  // load to $5 in EX
                    MemtoRegE = 1; RegWriteE = 1; WriteRegE = 5; RtE = 5;
                    exp_q.push_back(mk(3'b111, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
                end
                1: begin  // load now in MEM, bubble in EX
                    MemtoRegM = 1; RegWriteM = 1; WriteRegM = 5;
                    exp_q.push_back(mk(3'b111, 3'b000, 2'b00, 2'b00, 1'b1, 1'b0));
                end
                2: begin  // load in WB, bubble in MEM
                    RegWriteW = 1; WriteRegW = 5;
                    exp_q.push_back(mk(3'b000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
                end
                3: begin  // ALU result for $6 in EX
                    RtD = 6; RegWriteE = 1; WriteRegE = 6;
                    exp_q.push_back(mk(3'b111, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
                end
                default: begin  // ALU result now in MEM, forwarded to ID
                    RtD = 6; RegWriteM = 1; WriteRegM = 6;
                    exp_q.push_back(mk(3'b000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b1));
                end
            endcase
            @(negedge CLK);
            got = observe(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL branch c%0d got=%h want=%h", c, got, want);
            end
            next_cycle();
        end
    endtask

    // Push at c0; when with_pop, a PopE pulse at c2 (mid-STK for 4/6, a fresh op for 2).
    task automatic test_stack(input bit with_pop, input bit with_lw);
        obs_t got, want;
        logic [2:0] hold_t [6];
        logic [2:0] busy_t [6];
        hold_t = '{3'b111, 3'b110, 3'b110, 3'b100, 3'b100, 3'b000};
        busy_t = '{3'b000, 3'b110, 3'b110, 3'b100, 3'b100, 3'b000};
        if (with_pop) hold_t[2] = 3'b111;
        for (int c = 0; c < 6; c++) begin
            idle();
            if (c == 0) begin
                PushE = 1;
                if (with_lw) begin
                    MemtoRegE = 1; RtE = 9; RtD = 9;
                end
            end
            if (c == 2 && with_pop) PopE = 1;
            exp_q.push_back(mk(hold_t[c], busy_t[c], 2'b00, 2'b00, 1'b0, 1'b0));
            @(negedge CLK);
            got = observe(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL stack p%0d l%0d c%0d got=%h want=%h",
                         with_pop, with_lw, c, got, want);
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_stk();
        obs_t got, want;
        for (int c = 0; c < 5; c++) begin
            idle();
            case (c)
                0: begin
                    PushE = 1;
                    exp_q.push_back(mk(3'b111, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
                end
                1: exp_q.push_back(mk(3'b110, 3'b110, 2'b00, 2'b00, 1'b0, 1'b0));
                2: begin  // second STK cycle: reset with active inputs
                    reset = 1'b1;
                    PushE = 1; MemtoRegE = 1; RtE = 9; RtD = 9;
                    exp_q.push_back(mk(3'b000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
                end
                default: begin
                    reset = 1'b0;
                    exp_q.push_back(mk(3'b000, 3'b000, 2'b00, 2'b00, 1'b0, 1'b0));
                end
            endcase
            @(negedge CLK);
            got = observe(); want = exp_q.pop_front(); checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL reset_mid_stk c%0d got=%h want=%h", c, got, want);
            end
            next_cycle();
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        #1;
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_stack(1'b1, 1'b0);
        test_stack(1'b0, 1'b1);
        test_reset_mid_stk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
